// File: rtl/io_switch_port.sv
// io_switch_port: synchronizes and debounces two slide switches, latches edges, and exposes
// LEVEL/EDGE read registers with clear-on-read edge flags. Define SWPORT_IRQ_EN to add the irq output.
module io_switch_port #(
    parameter int DB_CNT = 4,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_sw0,
    input  logic              io_sw1,
    input  logic              rd_en,
    input  logic [1:0]        addr,
    output logic [DATA_W-1:0] rdata
`ifdef SWPORT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [7:0] CNT_MAX   = 8'(DB_CNT - 1);
    localparam logic [1:0] ADDR_LVL  = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;

    logic [1:0]        s1;
    logic [1:0]        s2;
    logic [1:0]        db;
    logic [1:0]        rise;
    logic [1:0]        fall;
    logic [7:0]        cnt [2];
    logic [1:0]        db_upd;
    logic [1:0]        rise_set;
    logic [1:0]        fall_set;
    logic              edge_rd;
    logic [DATA_W-1:0] rd_mux;

    // A debounced level flips when the synchronized input has disagreed for DB_CNT straight cycles.
    assign db_upd[0] = (s2[0] != db[0]) && (cnt[0] == CNT_MAX);
    assign db_upd[1] = (s2[1] != db[1]) && (cnt[1] == CNT_MAX);
    assign rise_set  = db_upd & s2;
    assign fall_set  = db_upd & ~s2;
    assign edge_rd   = rd_en && (addr == ADDR_EDGE);

    always_comb begin
        // NOTE: default first so every path assigns rd_mux and no latch is inferred.
        rd_mux = '0;
        case (addr)
            ADDR_LVL:  rd_mux[1:0] = db;
            ADDR_EDGE: rd_mux[3:0] = {fall, rise};
            default:   rd_mux = '0;
        endcase
    end

    // NOTE: non-blocking assignments keep s1->s2 a true two-stage pipeline regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            db     <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
            rise   <= '0;
            fall   <= '0;
            rdata  <= '0;
        end else begin
            s1 <= {io_sw1, io_sw0};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (db_upd[i]) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
            // NOTE: a clearing read drops old flags but keeps any set on this same edge (set wins).
            if (edge_rd) begin
                rise <= rise_set;
                fall <= fall_set;
            end else begin
                rise <= rise | rise_set;
                fall <= fall | fall_set;
            end
            if (rd_en) begin
                rdata <= rd_mux;
            end
        end
    end

`ifdef SWPORT_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |{rise, fall};
        end
    end
`endif

endmodule

// File: tb/tb_io_switch_port.sv
// Bench for io_switch_port: a directed vector table, an irq sequence when SWPORT_IRQ_EN is set,
// and randomized switch/read traffic, all compared against a sample-history reference model.
module tb_io_switch_port;

    localparam int DB_CNT = 4;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_sw0;
    logic              io_sw1;
    logic              rd_en;
    logic [1:0]        addr;
    logic [DATA_W-1:0] rdata;
`ifdef SWPORT_IRQ_EN
    logic              irq;
`endif

    int checks   = 0;
    int failures = 0;

    io_switch_port #(.DB_CNT(DB_CNT), .DATA_W(DATA_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_sw0 (io_sw0),
        .io_sw1 (io_sw1),
        .rd_en  (rd_en),
        .addr   (addr),
        .rdata  (rdata)
`ifdef SWPORT_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: bit k of m_hist holds the raw switch sample taken k+1 edges ago.
    logic [DB_CNT:0]   m_hist [2];
    logic [1:0]        m_db;
    logic [1:0]        m_rise;
    logic [1:0]        m_fall;
    logic [DATA_W-1:0] m_rdata;
    logic              m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic sw0, input logic sw1,
                              input logic rd, input logic [1:0] a);
        logic [1:0]        sw;
        logic [1:0]        upd;
        logic [1:0]        rise_new;
        logic [1:0]        fall_new;
        logic [DATA_W-1:0] rd_val;
        sw = {sw1, sw0};
        if (rst) begin
            m_hist[0] = '0;
            m_hist[1] = '0;
            m_db      = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_rdata   = '0;
            m_irq     = 1'b0;
            return;
        end
        rd_val = '0;
        if (a == 2'd0) rd_val[1:0] = m_db;
        else if (a == 2'd1) rd_val[3:0] = {m_fall, m_rise};
        m_irq = |{m_rise, m_fall};
        if (rd) m_rdata = rd_val;
        // The level flips once the DB_CNT most recent synchronized samples all disagree with it.
        for (int i = 0; i < 2; i++) begin
            upd[i] = 1'b1;
            for (int k = 1; k <= DB_CNT; k++) begin
                if (m_hist[i][k] == m_db[i]) upd[i] = 1'b0;
            end
        end
        rise_new = upd & ~m_db;
        fall_new = upd & m_db;
        if (rd && a == 2'd1) begin
            m_rise = rise_new;
            m_fall = fall_new;
        end else begin
            m_rise = m_rise | rise_new;
            m_fall = m_fall | fall_new;
        end
        m_db = m_db ^ upd;
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = {m_hist[i][DB_CNT-1:0], sw[i]};
        end
    endtask

    task automatic step(input logic sw0, input logic sw1, input logic rd,
                        input logic [1:0] a, input logic rst);
        io_sw0 = sw0;
        io_sw1 = sw1;
        rd_en  = rd;
        addr   = a;
        reset  = rst;
        @(posedge clock);
        model_edge(rst, sw0, sw1, rd, a);
        #1;
        check("model_rdata", 32'(rdata), 32'(m_rdata));
`ifdef SWPORT_IRQ_EN
        check("model_irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    typedef struct {
        logic        sw0;
        logic        sw1;
        logic        rd;
        logic [1:0]  addr;
        int          cycles;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    initial begin
        // reset with sw0 held high: db[0] rises on the 6th edge after release
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 5,  1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1,  1'b1, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1,  1'b1, 16'h0001};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0001};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0000};
        // bounce rejection on sw1, then a long enough pulse
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3,  1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8,  1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1,  1'b1, 16'h0001};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 6,  1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 1,  1'b1, 16'h0002};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd0, 1,  1'b1, 16'h0003};
        // fall detection on sw0
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 10, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 2'd1, 1,  1'b1, 16'h0004};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd0, 1,  1'b1, 16'h0002};
        // set-wins race: EDGE read lands on the edge where db[1] falls
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 5,  1'b0, 16'h0000};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0000};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0008};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0000};
        // hold with rd_en low, then unmapped addresses
        vecs[19] = '{1'b1, 1'b0, 1'b0, 2'd0, 6,  1'b0, 16'h0000};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 2'd0, 1,  1'b1, 16'h0001};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 2'd1, 5,  1'b1, 16'h0001};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 2'd2, 1,  1'b1, 16'h0000};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 2'd3, 1,  1'b1, 16'h0000};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 2'd1, 1,  1'b1, 16'h0001};

        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        check("reset_rdata", 32'(rdata), 32'h0);

        for (int v = 0; v < NVEC; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step(vecs[v].sw0, vecs[v].sw1, vecs[v].rd, vecs[v].addr, 1'b0);
            end
            if (vecs[v].chk) check($sformatf("vec%0d", v), 32'(rdata), 32'(vecs[v].exp));
        end

`ifdef SWPORT_IRQ_EN
        // sw0 falls, flag cleared; then a sw0 rise drives irq high and a read drops it
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        check("irq_before_clear", 32'(irq), 32'h1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("irq_after_clear", 32'(irq), 32'h0);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check("irq_flag_edge", 32'(irq), 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check("irq_rise", 32'(irq), 32'h1);
        step(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        check("irq_read_edge", 32'(irq), 32'h1);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check("irq_cleared", 32'(irq), 32'h0);
`endif

        begin
            logic       r0;
            logic       r1;
            logic       rd;
            logic [1:0] a;
            logic       rst;
            r0 = io_sw0;
            r1 = io_sw1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(7) == 0) r0 = ~r0;
                if ($urandom_range(9) == 0) r1 = ~r1;
                rd  = ($urandom_range(2) == 0);
                a   = 2'($urandom_range(3));
                rst = ($urandom_range(499) == 0);
                step(r0, r1, rd, a, rst);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
